// File: rtl/pc_ctrl_pkg.sv
// Shared constants and types for the next-PC sequencer and its redirect buffer.
package pc_ctrl_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 4;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_REDIR = 2'd1,
        PEND_TRAP  = 2'd2
    } pend_kind_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect/trap register used while an instruction fetch miss is outstanding.
module pc_redirect_buf
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_trap,
    input  logic              wr_redir,
    input  logic [XLEN_P-1:0] trap_target,
    input  logic [XLEN_P-1:0] redir_target,
    output pend_kind_t        kind,
    output logic [XLEN_P-1:0] target
);

    pend_kind_t        kind_r;
    logic [XLEN_P-1:0] target_r;

    // Trap overwrites anything; a redirect may never displace a pending trap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            kind_r   <= PEND_NONE;
            target_r <= {XLEN_P{1'b0}};
        end else if (wr_trap) begin
            kind_r   <= PEND_TRAP;
            target_r <= trap_target;
        end else if (wr_redir && (kind_r != PEND_TRAP)) begin
            kind_r   <= PEND_REDIR;
            target_r <= redir_target;
        end else begin
            kind_r   <= kind_r;
            target_r <= target_r;
        end
    end

    assign kind   = kind_r;
    assign target = target_r;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates trap, redirect, stall and fetch handshake for the PC register.
module pc_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN_P       = XLEN,
    parameter logic [XLEN_P-1:0] RESET_VECTOR = {XLEN_P{1'b0}},
    parameter int              INSTR_BYTES_P = INSTR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN_P-1:0] pc_cur,
    output logic [XLEN_P-1:0] pc_next,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [XLEN_P-1:0] redirect_target,
    input  logic              trap_valid,
    input  logic [XLEN_P-1:0] trap_vector,
    input  logic              halt_i,
    output logic              imem_req,
    input  logic              imem_ready,
    output logic              fetch_valid,
    output logic              flush_o,
    output logic              halted
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    pend_kind_t        pend_kind_s;
    logic [XLEN_P-1:0] pend_target_s;
    logic [XLEN_P-1:0] win_target_s;
    logic [XLEN_P-1:0] pc_inc_s;
    logic              buf_clr_s;
    logic              buf_wr_trap_s;
    logic              buf_wr_redir_s;
    logic              halt_take_s;
    logic              run_miss_s;
    logic              wait_discard_s;

    assign pc_inc_s    = pc_cur + XLEN_P'(INSTR_BYTES_P);
    assign halt_take_s = halt_i && !trap_valid;

    pc_redirect_buf #(.XLEN_P(XLEN_P)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .clr          (buf_clr_s),
        .wr_trap      (buf_wr_trap_s),
        .wr_redir     (buf_wr_redir_s),
        .trap_target  (trap_vector),
        .redir_target (redirect_target),
        .kind         (pend_kind_s),
        .target       (pend_target_s)
    );

    // Winner when a miss resolves: new trap, then pending trap, then new redirect, then pending redirect.
    always_comb begin
        win_target_s = pend_target_s;
        if (trap_valid) begin
            win_target_s = trap_vector;
        end else if (pend_kind_s == PEND_TRAP) begin
            win_target_s = pend_target_s;
        end else if (redirect_valid) begin
            win_target_s = redirect_target;
        end else begin
            win_target_s = pend_target_s;
        end
    end

    assign run_miss_s     = !trap_valid && !redirect_valid && !stall_i && !imem_ready;
    assign wait_discard_s = (pend_kind_s != PEND_NONE) || trap_valid || redirect_valid;

    // Output decode and next-state selection.
    always_comb begin
        state_nxt_s    = state_r;
        pc_next        = pc_cur;
        imem_req       = 1'b0;
        fetch_valid    = 1'b0;
        flush_o        = 1'b0;
        halted         = 1'b0;
        buf_clr_s      = 1'b0;
        buf_wr_trap_s  = 1'b0;
        buf_wr_redir_s = 1'b0;
        if (rst) begin
            pc_next     = RESET_VECTOR;
            state_nxt_s = ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    pc_next     = RESET_VECTOR;
                    state_nxt_s = ST_RUN;
                end
                ST_RUN: begin
                    imem_req = 1'b1;
                    if (trap_valid) begin
                        pc_next = trap_vector;
                        flush_o = 1'b1;
                    end else if (redirect_valid) begin
                        pc_next = redirect_target;
                        flush_o = 1'b1;
                    end else if (stall_i) begin
                        pc_next = pc_cur;
                    end else if (imem_ready) begin
                        pc_next     = pc_inc_s;
                        fetch_valid = 1'b1;
                    end else begin
                        pc_next = pc_cur;
                    end
                    state_nxt_s = halt_take_s ? ST_HALT : (run_miss_s ? ST_WAIT : ST_RUN);
                end
                ST_WAIT: begin
                    imem_req       = 1'b1;
                    flush_o        = trap_valid || redirect_valid;
                    buf_wr_trap_s  = trap_valid;
                    buf_wr_redir_s = redirect_valid;
                    buf_clr_s      = imem_ready || halt_take_s;
                    if (imem_ready && wait_discard_s) begin
                        pc_next = win_target_s;
                    end else if (imem_ready && !stall_i) begin
                        pc_next     = pc_inc_s;
                        fetch_valid = 1'b1;
                    end else begin
                        pc_next = pc_cur;
                    end
                    state_nxt_s = halt_take_s ? ST_HALT : (imem_ready ? ST_RUN : ST_WAIT);
                end
                ST_HALT: begin
                    halted  = 1'b1;
                    pc_next = pc_cur;
                end
                default: begin
                    pc_next     = RESET_VECTOR;
                    state_nxt_s = ST_BOOT;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; the bench plays the PC register by setting pc_cur.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_cur;
    logic [63:0] pc_next;
    logic        stall_i;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        trap_valid;
    logic [63:0] trap_vector;
    logic        halt_i;
    logic        imem_req;
    logic        imem_ready;
    logic        fetch_valid;
    logic        flush_o;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .stall_i         (stall_i),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .halt_i          (halt_i),
        .imem_req        (imem_req),
        .imem_ready      (imem_ready),
        .fetch_valid     (fetch_valid),
        .flush_o         (flush_o),
        .halted          (halted)
    );

    // Advance to just after the next rising edge and clear the one-shot inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst             = 1'b0;
        stall_i         = 1'b0;
        redirect_valid  = 1'b0;
        trap_valid      = 1'b0;
        halt_i          = 1'b0;
        imem_ready      = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_cur = 64'h1234; imem_ready = 1'b1; redirect_valid = 1'b1;
        redirect_target = 64'hDEAD; trap_valid = 1'b1; trap_vector = 64'hBEEF; halt_i = 1'b1; stall_i = 1'b0;
        settle();
        checks++;
        if (pc_next !== 64'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0 || flush_o !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL rst_cycle: pc_next=%h req=%b fv=%b fl=%b h=%b, want 0 0 0 0 0", pc_next, imem_req, fetch_valid, flush_o, halted);
        end
        cyc();
        pc_cur = 64'h0; imem_ready = 1'b1; trap_valid = 1'b1; trap_vector = 64'hBEEF;
        settle();
        checks++;
        if (pc_next !== 64'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0 || flush_o !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL boot: pc_next=%h req=%b fv=%b fl=%b, want 0 0 0 0", pc_next, imem_req, fetch_valid, flush_o);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        exp_pc = 64'h0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pc_cur = exp_pc; imem_ready = 1'b1;
            exp_pc = exp_pc + 64'd4;
            settle();
            checks++;
            if (pc_next !== exp_pc || fetch_valid !== 1'b1 || imem_req !== 1'b1 || flush_o !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: pc_next=%h fv=%b req=%b, want %h 1 1", i, pc_next, fetch_valid, imem_req, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cyc();
            pc_cur = 64'h100; stall_i = 1'b1; imem_ready = 1'b1;
            settle();
            checks++;
            if (pc_next !== 64'h100 || fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: pc_next=%h fv=%b, want 100 0", i, pc_next, fetch_valid);
            end
        end
        cyc();
        pc_cur = 64'h100; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h104 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc_next=%h fv=%b, want 104 1", pc_next, fetch_valid);
        end
    endtask

    task automatic test_trap_redirect();
        cyc();
        pc_cur = 64'h200; imem_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 64'h800;
        trap_valid = 1'b1; trap_vector = 64'h1000;
        settle();
        checks++;
        if (pc_next !== 64'h1000 || flush_o !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_over_redir: pc_next=%h fl=%b fv=%b, want 1000 1 0", pc_next, flush_o, fetch_valid);
        end
    endtask

    task automatic test_miss_redirect();
        cyc();
        pc_cur = 64'h300;
        settle();
        checks++;
        if (pc_next !== 64'h300 || fetch_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL miss_enter: pc_next=%h fv=%b req=%b, want 300 0 1", pc_next, fetch_valid, imem_req);
        end
        cyc();
        pc_cur = 64'h300; redirect_valid = 1'b1; redirect_target = 64'h900;
        settle();
        checks++;
        if (pc_next !== 64'h300 || flush_o !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_redir_latch: pc_next=%h fl=%b fv=%b, want 300 1 0", pc_next, flush_o, fetch_valid);
        end
        cyc();
        pc_cur = 64'h300; stall_i = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h300 || flush_o !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL miss_hold: pc_next=%h fl=%b req=%b, want 300 0 1", pc_next, flush_o, imem_req);
        end
        cyc();
        pc_cur = 64'h300; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h900 || fetch_valid !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_redir_apply: pc_next=%h fv=%b fl=%b, want 900 0 0", pc_next, fetch_valid, flush_o);
        end
    endtask

    task automatic test_trap_pending();
        cyc();
        pc_cur = 64'h300;
        cyc();
        pc_cur = 64'h300; trap_valid = 1'b1; trap_vector = 64'h1000;
        settle();
        checks++;
        if (pc_next !== 64'h300 || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_trap_latch: pc_next=%h fl=%b, want 300 1", pc_next, flush_o);
        end
        cyc();
        pc_cur = 64'h300; redirect_valid = 1'b1; redirect_target = 64'h900;
        settle();
        checks++;
        if (pc_next !== 64'h300 || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_redir_try: pc_next=%h fl=%b, want 300 1", pc_next, flush_o);
        end
        cyc();
        pc_cur = 64'h300; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h1000 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_trap_wins: pc_next=%h fv=%b, want 1000 0", pc_next, fetch_valid);
        end
    endtask

    task automatic test_wrap();
        cyc();
        pc_cur = 64'hFFFF_FFFF_FFFF_FFFC; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h0 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc_next=%h fv=%b, want 0 1", pc_next, fetch_valid);
        end
    endtask

    task automatic test_wait_stall();
        cyc();
        pc_cur = 64'h700;
        cyc();
        pc_cur = 64'h700; imem_ready = 1'b1; stall_i = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h700 || fetch_valid !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_refetch: pc_next=%h fv=%b fl=%b, want 700 0 0", pc_next, fetch_valid, flush_o);
        end
        cyc();
        pc_cur = 64'h700; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h704 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_back_in_run: pc_next=%h fv=%b, want 704 1", pc_next, fetch_valid);
        end
    endtask

    task automatic test_halt();
        cyc();
        pc_cur = 64'h400; imem_ready = 1'b1; halt_i = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h404 || fetch_valid !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_req: pc_next=%h fv=%b h=%b, want 404 1 0", pc_next, fetch_valid, halted);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            pc_cur = 64'h404; imem_ready = 1'b1;
            redirect_valid = 1'b1; redirect_target = 64'h900;
            trap_valid = (i == 1); trap_vector = 64'h1000;
            settle();
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc_next !== 64'h404 || flush_o !== 1'b0 || fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL halted_%0d: h=%b req=%b pc_next=%h fl=%b fv=%b, want 1 0 404 0 0", i, halted, imem_req, pc_next, flush_o, fetch_valid);
            end
        end
    endtask

    task automatic test_reset_wait();
        cyc();
        rst = 1'b1;
        cyc();
        pc_cur = 64'h0;
        cyc();
        pc_cur = 64'h500;
        cyc();
        pc_cur = 64'h500; redirect_valid = 1'b1; redirect_target = 64'hA00;
        cyc();
        pc_cur = 64'h500; rst = 1'b1; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wait: pc_next=%h req=%b fv=%b, want 0 0 0", pc_next, imem_req, fetch_valid);
        end
        cyc();
        pc_cur = 64'h0; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_boot: pc_next=%h req=%b, want 0 0", pc_next, imem_req);
        end
        cyc();
        pc_cur = 64'h4;
        cyc();
        pc_cur = 64'h4; imem_ready = 1'b1;
        settle();
        checks++;
        if (pc_next !== 64'h8 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL stale_pending: pc_next=%h fv=%b, want 8 1", pc_next, fetch_valid);
        end
    endtask

    initial begin
        rst = 1'b1; pc_cur = 64'h0; stall_i = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
        trap_valid = 1'b0; trap_vector = 64'h0; halt_i = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_trap_redirect();
        test_miss_redirect();
        test_trap_pending();
        test_wrap();
        test_wait_stall();
        test_halt();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
